// File: rtl/cmp_pkg.sv
// ---------------------------------------------------------------------------
// cmp_pkg
// Shared types and constants for the bit-serial magnitude comparator and the
// board display blocks that reuse its seven-segment glyph encoder.
//   state_t   : comparator FSM states
//   result_t  : one-hot {lt, eq, gt} comparison result
//   SEG_*     : active-low {g,f,e,d,c,b,a} glyphs
// ---------------------------------------------------------------------------
package cmp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic lt;
      logic eq;
      logic gt;
   } result_t;

   localparam result_t RES_NONE = 3'b000;
   localparam result_t RES_LT   = 3'b100;
   localparam result_t RES_EQ   = 3'b010;
   localparam result_t RES_GT   = 3'b001;

   // Active-low glyphs, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_L     = 7'b1000111;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_H     = 7'b0001001;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg_glyph_enc.sv
// ---------------------------------------------------------------------------
// seg_glyph_enc
// Combinational decoder from a {lt, eq, gt} result to an active-low
// seven-segment glyph: L, E, H, or blank when no flag is set.
//   lt_i, eq_i, gt_i : result flags (expected one-hot or all zero)
//   seg_o            : {g,f,e,d,c,b,a}, active-low
// ---------------------------------------------------------------------------
module seg_glyph_enc
   import cmp_pkg::*;
(
   input  logic       lt_i,
   input  logic       eq_i,
   input  logic       gt_i,
   output logic [6:0] seg_o
);

   // Priority order only matters for illegal multi-hot inputs.
   always_comb begin
      if (lt_i) begin
         seg_o = SEG_L;
      end else if (eq_i) begin
         seg_o = SEG_E;
      end else if (gt_i) begin
         seg_o = SEG_H;
      end else begin
         seg_o = SEG_BLANK;
      end
   end

endmodule

// File: rtl/seq_mag_comparator.sv
// ---------------------------------------------------------------------------
// seq_mag_comparator
// Bit-serial MSB-first magnitude comparator. Operands are captured on an
// accepted start and scanned one bit per clock in unsigned or two's-complement
// mode, optionally stopping at the first differing bit pair.
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   start           : request, honoured only in IDLE or DONE
//   a, b            : WIDTH-bit operands, captured on an accepted start
//   is_signed       : two's-complement mode (gated by SIGNED_EN)
//   busy            : high while a compare is in progress
//   done            : one-cycle pulse when the result flags update
//   lt, eq, gt      : registered one-hot result, held until next decision
//   seg             : active-low glyph of the current result
// ---------------------------------------------------------------------------
module seq_mag_comparator
   import cmp_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int SIGNED_EN  = 1,
   parameter int EARLY_EXIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             is_signed,
   output logic             busy,
   output logic             done,
   output logic             lt,
   output logic             eq,
   output logic             gt,
   output logic [6:0]       seg
);

   localparam int              IDX_W   = $clog2(WIDTH);
   localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);
   localparam logic             SGN_EN  = (SIGNED_EN != 0);
   localparam logic             EXIT_EN = (EARLY_EXIT != 0);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, b_sh_q;
   logic             sgn_q;
   logic [IDX_W-1:0] idx_q;
   result_t          pend_q;
   logic             pend_vld_q;
   result_t          res_q;

   logic    accept;
   logic    bit_a, bit_b, differ, last_bit, decide;
   result_t cur_res, final_res;

   // ------------------------------------------------------------------
   // Bit-compare datapath
   // ------------------------------------------------------------------
   assign accept   = start && ((state_q == IDLE) || (state_q == DONE));
   assign bit_a    = a_sh_q[idx_q];
   assign bit_b    = b_sh_q[idx_q];
   assign differ   = bit_a ^ bit_b;
   assign last_bit = (idx_q == '0);
   assign decide   = (state_q == RUN) && ((differ && EXIT_EN) || last_bit);

   // In signed mode the sign bit has inverted weight: a 1 there means less.
   always_comb begin
      if (sgn_q && (idx_q == IDX_MSB)) begin
         cur_res = bit_a ? RES_LT : RES_GT;
      end else begin
         cur_res = bit_a ? RES_GT : RES_LT;
      end
   end

   // A pending (MSB-most) difference outranks whatever the final bit says.
   always_comb begin
      if (pend_vld_q) begin
         final_res = pend_q;
      end else if (differ) begin
         final_res = cur_res;
      end else begin
         final_res = RES_EQ;
      end
   end

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling the
         // pre-edge values, so process ordering cannot change behaviour.
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch forms.
      state_d = state_q;
      case (state_q)
         IDLE:    if (start)  state_d = RUN;
         RUN:     if (decide) state_d = DONE;
         DONE:    state_d = start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------
   always_comb begin
      busy = (state_q == RUN);
      done = (state_q == DONE);
   end

   // ------------------------------------------------------------------
   // Operand, index and pending-result registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: operand registers are reset as well; they are tiny and this
         // keeps the idle datapath deterministic after power-up.
         a_sh_q     <= '0;
         b_sh_q     <= '0;
         sgn_q      <= 1'b0;
         idx_q      <= IDX_MSB;
         pend_q     <= RES_NONE;
         pend_vld_q <= 1'b0;
      end else if (accept) begin
         a_sh_q     <= a;
         b_sh_q     <= b;
         sgn_q      <= is_signed & SGN_EN;
         idx_q      <= IDX_MSB;
         pend_q     <= RES_NONE;
         pend_vld_q <= 1'b0;
      end else if ((state_q == RUN) && !decide) begin
         idx_q <= idx_q - IDX_W'(1);
         // Only the MSB-most difference matters; later ones are ignored.
         if (differ && !pend_vld_q) begin
            pend_q     <= cur_res;
            pend_vld_q <= 1'b1;
         end
      end
   end

   // Result flags change only on a decision edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q <= RES_NONE;
      end else if (decide) begin
         res_q <= final_res;
      end
   end

   assign lt = res_q.lt;
   assign eq = res_q.eq;
   assign gt = res_q.gt;

   seg_glyph_enc u_seg (
      .lt_i  (res_q.lt),
      .eq_i  (res_q.eq),
      .gt_i  (res_q.gt),
      .seg_o (seg)
   );

endmodule

// File: tb/tb_seq_mag_comparator.sv
// ---------------------------------------------------------------------------
// tb_seq_mag_comparator
// Three WIDTH=8 instances share the stimulus:
//   dut0 : SIGNED_EN=1, EARLY_EXIT=1
//   dut1 : SIGNED_EN=1, EARLY_EXIT=0 (always a full scan)
//   dut2 : SIGNED_EN=0, EARLY_EXIT=1 (is_signed ignored)
// Expected results are queued when start is driven and popped when a done
// pulse is seen, together with the cycle the done was due.
// ---------------------------------------------------------------------------
module tb_seq_mag_comparator;

   localparam int W = 8;
   localparam logic [2:0] R_LT = 3'b100;
   localparam logic [2:0] R_EQ = 3'b010;
   localparam logic [2:0] R_GT = 3'b001;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a, b;
   logic         is_signed;

   logic       busy0, done0, lt0, eq0, gt0;
   logic       busy1, done1, lt1, eq1, gt1;
   logic       busy2, done2, lt2, eq2, gt2;
   logic [6:0] seg0, seg1, seg2;

   seq_mag_comparator #(.WIDTH(W), .SIGNED_EN(1), .EARLY_EXIT(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .is_signed(is_signed),
      .busy(busy0), .done(done0), .lt(lt0), .eq(eq0), .gt(gt0), .seg(seg0));

   seq_mag_comparator #(.WIDTH(W), .SIGNED_EN(1), .EARLY_EXIT(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .is_signed(is_signed),
      .busy(busy1), .done(done1), .lt(lt1), .eq(eq1), .gt(gt1), .seg(seg1));

   seq_mag_comparator #(.WIDTH(W), .SIGNED_EN(0), .EARLY_EXIT(1)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .is_signed(is_signed),
      .busy(busy2), .done(done2), .lt(lt2), .eq(eq2), .gt(gt2), .seg(seg2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] seg_of(input logic [2:0] r);
      case (r)
         3'b100:  return 7'b1000111;
         3'b010:  return 7'b0000110;
         3'b001:  return 7'b0001001;
         default: return 7'b1111111;
      endcase
   endfunction

   // ------------------------------------------------------------------
   // Scoreboard
   // ------------------------------------------------------------------
   typedef struct {
      int         id;
      logic [2:0] res;
      int         due;
   } exp_t;

   exp_t sb[$];

   // Called at the negedge where start is set: edge 0 is the next posedge,
   // so a result with latency lat is visible when cyc == cyc_now + 1 + lat.
   task automatic push3(input logic [2:0] res_s, input logic [2:0] res_u, input int lat);
      exp_t e;
      e.id = 0; e.res = res_s; e.due = cyc + 1 + lat; sb.push_back(e);
      e.id = 1; e.res = res_s; e.due = cyc + 1 + W;   sb.push_back(e);
      e.id = 2; e.res = res_u; e.due = cyc + 1 + lat; sb.push_back(e);
   endtask

   task automatic pop_check(input int id, input logic dn, input logic [2:0] res,
                            input logic [6:0] sg);
      int k;
      k = -1;
      foreach (sb[i]) if (k < 0 && sb[i].id == id) k = i;
      if (k < 0) begin
         check($sformatf("dut%0d_unexpected_done", id), dn, 1'b0);
      end else begin
         check($sformatf("dut%0d_result", id), res, sb[k].res);
         check($sformatf("dut%0d_done_cycle", id), cyc, sb[k].due);
         check($sformatf("dut%0d_seg", id), sg, seg_of(sb[k].res));
         sb.delete(k);
      end
   endtask

   always @(negedge clk) if (rst_n && done0) pop_check(0, done0, {lt0, eq0, gt0}, seg0);
   always @(negedge clk) if (rst_n && done1) pop_check(1, done1, {lt1, eq1, gt1}, seg1);
   always @(negedge clk) if (rst_n && done2) pop_check(2, done2, {lt2, eq2, gt2}, seg2);

   task automatic wait_idle();
      for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      @(negedge clk);
   endtask

   task automatic drive(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vs);
      a         = va;
      b         = vb;
      is_signed = vs;
      start     = 1'b1;
   endtask

   // ------------------------------------------------------------------
   // Vector table
   // ------------------------------------------------------------------
   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         s;
      logic [2:0]   res;    // SIGNED_EN=1 result
      logic [2:0]   res_u;  // SIGNED_EN=0 result
      int           lat;    // early-exit latency in cycles
   } vec_t;

   vec_t vecs[10];

   initial begin
      vecs[0] = '{8'h10, 8'h10, 1'b0, R_EQ, R_EQ, 8};
      vecs[1] = '{8'h9B, 8'h9A, 1'b0, R_GT, R_GT, 8};
      vecs[2] = '{8'hEF, 8'h0F, 1'b1, R_LT, R_GT, 1};
      vecs[3] = '{8'hEF, 8'h0F, 1'b0, R_GT, R_GT, 1};
      vecs[4] = '{8'h05, 8'h03, 1'b1, R_GT, R_GT, 6};
      vecs[5] = '{8'h80, 8'h7F, 1'b1, R_LT, R_GT, 1};
      vecs[6] = '{8'hFF, 8'hFE, 1'b1, R_GT, R_GT, 8};
      vecs[7] = '{8'h00, 8'hFF, 1'b1, R_GT, R_LT, 1};
      vecs[8] = '{8'h3C, 8'h3C, 1'b1, R_EQ, R_EQ, 8};
      vecs[9] = '{8'h40, 8'h41, 1'b0, R_LT, R_LT, 8};

      rst_n     = 1'b0;
      start     = 1'b0;
      a         = '0;
      b         = '0;
      is_signed = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_busy", busy0, 1'b0);
      check("rst_done", done0, 1'b0);
      check("rst_flags", {lt0, eq0, gt0}, 3'b000);
      check("rst_seg", seg0, 7'b1111111);
      check("rst_flags_dut1", {lt1, eq1, gt1}, 3'b000);
      check("rst_seg_dut2", seg2, 7'b1111111);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Table-driven compares
      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].a, vecs[i].b, vecs[i].s);
         push3(vecs[i].res, vecs[i].res_u, vecs[i].lat);
         @(negedge clk);
         start = 1'b0;
         check($sformatf("v%0d_busy", i), busy0, 1'b1);
         wait_idle();
         check($sformatf("v%0d_flags_hold", i), {lt0, eq0, gt0}, vecs[i].res);
         check($sformatf("v%0d_idle_busy", i), busy0, 1'b0);
      end

      // start pulsed mid-RUN is ignored
      drive(8'h10, 8'h10, 1'b0);
      push3(R_EQ, R_EQ, 8);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      drive(8'hFF, 8'h00, 1'b1);
      check("midrun_busy", busy0, 1'b1);
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      check("midrun_flags", {lt0, eq0, gt0}, R_EQ);

      // Back-to-back: start held during the done cycle
      drive(8'h10, 8'h10, 1'b0);
      push3(R_EQ, R_EQ, 8);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 20 && !done0; i++) @(negedge clk);
      check("b2b_done_seen", done0, 1'b1);
      drive(8'hEF, 8'h0F, 1'b1);
      push3(R_LT, R_GT, 1);
      @(negedge clk);
      start = 1'b0;
      check("b2b_busy", busy0, 1'b1);
      check("b2b_done_low", done0, 1'b0);
      wait_idle();
      check("b2b_flags", {lt0, eq0, gt0}, R_LT);

      // Reset asserted at edge 3 of a compare
      drive(8'h10, 8'h10, 1'b0);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      sb.delete();
      #1;
      check("abort_busy", busy0, 1'b0);
      check("abort_done", done0, 1'b0);
      check("abort_flags", {lt0, eq0, gt0}, 3'b000);
      check("abort_seg", seg0, 7'b1111111);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("abort_no_done_busy", busy0, 1'b0);
      check("abort_flags_after", {lt0, eq0, gt0}, 3'b000);

      // Fresh compare after reset release
      drive(vecs[1].a, vecs[1].b, vecs[1].s);
      push3(vecs[1].res, vecs[1].res_u, vecs[1].lat);
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      check("post_reset_flags", {lt0, eq0, gt0}, R_GT);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
